alu_multiciclo: RTL and testbench

- Parametrised, registered successor to the datapath ALU.
- Executes all single-cycle ops of the current ALU in one clock, adds SRA, SLTU, signed overflow, and iterative multiply (shift-add) and unsigned divide/remainder (restoring).
- Sits in the EX stage. The control unit stalls the pipeline while ocupado=1.
- One start/done handshake covers every op.

---
 rtl/alu_multiciclo.sv | 182 ++++++++++++++++++
 tb/tb_alu_multiciclo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multiciclo.sv
// alu_multiciclo: registered multi-cycle ALU for the EX stage.
//   Single-cycle ops (logic, add/sub, compares, shifts) finish one clock after
//   acceptance. MUL/MULHU (shift-add) and DIVU/REMU (restoring) iterate for
//   WIDTH clocks and complete WIDTH+1 clocks after acceptance.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   inicio            request, accepted when ocupado=0
//   entrada1/2        operands A/B, sampled at acceptance
//   alu_control       4-bit op code, sampled at acceptance
//   resultado         registered result, held between completions
//   zero, overflow    registered flags for resultado
//   ocupado           iterative op in progress, requests ignored
//   valido            one-cycle pulse when outputs are updated
module alu_multiciclo #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inicio,
   input  logic [WIDTH-1:0] entrada1,
   input  logic [WIDTH-1:0] entrada2,
   input  logic [3:0]       alu_control,
   output logic [WIDTH-1:0] resultado,
   output logic             zero,
   output logic             overflow,
   output logic             ocupado,
   output logic             valido
);

   typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

   // One spare bit so the counter can never wrap before reaching WIDTH-1.
   localparam int CW = SHW + 1;
   localparam logic [CW-1:0] ULTIMA = CW'(WIDTH - 1);

   estado_t estado, estado_prox;

   logic [CW-1:0]      contador;
   logic [1:0]         op_iter;     // 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
   logic [2*WIDTH-1:0] mul_acc;
   logic [2*WIDTH-1:0] mul_a;       // A shifted left by the iteration index
   logic [WIDTH-1:0]   mul_b;       // B shifted right; bit 0 is the current B[i]
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   div_quo;     // dividend bits shift out as quotient bits shift in
   logic [WIDTH-1:0]   div_dsr;

   logic               aceita;
   logic               iterativo;
   logic [WIDTH-1:0]   res_comb;
   logic               ovf_comb;
   logic [WIDTH-1:0]   soma, dif;
   logic [SHW-1:0]     sha;
   logic [WIDTH:0]     div_tmp, div_sub;
   logic [WIDTH-1:0]   res_iter;

   assign aceita    = inicio && (estado == OCIOSO);
   assign iterativo = (alu_control[3:2] == 2'b11);
   assign ocupado   = (estado != OCIOSO);

   // Single-cycle datapath
   assign soma = entrada1 + entrada2;
   assign dif  = entrada1 - entrada2;
   assign sha  = entrada2[SHW-1:0];

   always_comb begin
      res_comb = '0;
      ovf_comb = 1'b0;
      case (alu_control)
         4'b0010: begin
            res_comb = soma;
            ovf_comb = (entrada1[WIDTH-1] == entrada2[WIDTH-1]) &&
                       (soma[WIDTH-1] != entrada1[WIDTH-1]);
         end
         4'b0110: begin
            res_comb = dif;
            ovf_comb = (entrada1[WIDTH-1] != entrada2[WIDTH-1]) &&
                       (dif[WIDTH-1] != entrada1[WIDTH-1]);
         end
         4'b0000: res_comb = entrada1 & entrada2;
         4'b0001: res_comb = entrada1 | entrada2;
         4'b0100: res_comb = entrada1 ^ entrada2;
         4'b0101: res_comb = ~(entrada1 | entrada2);
         4'b0111: res_comb = {{(WIDTH-1){1'b0}}, ($signed(entrada1) < $signed(entrada2))};
         4'b1011: res_comb = {{(WIDTH-1){1'b0}}, (entrada1 < entrada2)};
         4'b1000: res_comb = entrada1 << sha;
         4'b1001: res_comb = entrada1 >> sha;
         4'b1010: res_comb = $unsigned($signed(entrada1) >>> sha);
         default: res_comb = '0;
      endcase
   end

   // Restoring divide step: bring down the next dividend bit, try subtracting.
   // A clear MSB of the difference means the divisor fit. With divisor 0 it
   // always fits, which yields all-ones quotient and remainder = dividend.
   assign div_tmp = {div_rem, div_quo[WIDTH-1]};
   assign div_sub = div_tmp - {1'b0, div_dsr};

   always_comb begin
      case (op_iter)
         2'b00:   res_iter = mul_acc[WIDTH-1:0];
         2'b01:   res_iter = mul_acc[2*WIDTH-1:WIDTH];
         2'b10:   res_iter = div_quo;
         default: res_iter = div_rem;
      endcase
   end

   // Next-state logic
   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO:  if (aceita && iterativo) estado_prox = CALC;
         CALC:    if (contador == ULTIMA)  estado_prox = FIM;
         FIM:     estado_prox = OCIOSO;
         default: estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado    <= OCIOSO;
         resultado <= '0;
         zero      <= 1'b1;
         overflow  <= 1'b0;
         valido    <= 1'b0;
         contador  <= '0;
         op_iter   <= '0;
         mul_acc   <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         div_rem   <= '0;
         div_quo   <= '0;
         div_dsr   <= '0;
      end else begin
         estado <= estado_prox;
         valido <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (aceita) begin
                  if (iterativo) begin
                     op_iter  <= alu_control[1:0];
                     contador <= '0;
                     mul_acc  <= '0;
                     mul_a    <= {{WIDTH{1'b0}}, entrada1};
                     mul_b    <= entrada2;
                     div_rem  <= '0;
                     div_quo  <= entrada1;
                     div_dsr  <= entrada2;
                  end else begin
                     resultado <= res_comb;
                     zero      <= (res_comb == '0);
                     overflow  <= ovf_comb;
                     valido    <= 1'b1;
                  end
               end
            end
            CALC: begin
               // Multiply and divide advance together; op_iter picks the result.
               if (mul_b[0]) mul_acc <= mul_acc + mul_a;
               mul_a    <= mul_a << 1;
               mul_b    <= mul_b >> 1;
               if (!div_sub[WIDTH]) begin
                  div_rem <= div_sub[WIDTH-1:0];
                  div_quo <= {div_quo[WIDTH-2:0], 1'b1};
               end else begin
                  div_rem <= div_tmp[WIDTH-1:0];
                  div_quo <= {div_quo[WIDTH-2:0], 1'b0};
               end
               contador <= contador + 1'b1;
            end
            FIM: begin
               resultado <= res_iter;
               zero      <= (res_iter == '0);
               overflow  <= 1'b0;
               valido    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo: a WIDTH=32 instance and a WIDTH=8 instance.
// Expected results are queued when a request is driven and popped when the
// matching DUT raises valido.
module tb_alu_multiciclo;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ini32, ini8;
   logic [31:0] a32, b32;
   logic [7:0]  a8, b8;
   logic [3:0]  op32, op8;
   logic [31:0] res32;
   logic [7:0]  res8;
   logic        z32, ov32, oc32, v32;
   logic        z8, ov8, oc8, v8;

   int checks   = 0;
   int failures = 0;
   exp_t q32[$];
   exp_t q8[$];

   always #5 clk = ~clk;

   alu_multiciclo #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(rst), .inicio(ini32), .entrada1(a32), .entrada2(b32),
      .alu_control(op32), .resultado(res32), .zero(z32), .overflow(ov32),
      .ocupado(oc32), .valido(v32)
   );

   alu_multiciclo #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst), .inicio(ini8), .entrada1(a8), .entrada2(b8),
      .alu_control(op8), .resultado(res8), .zero(z8), .overflow(ov8),
      .ocupado(oc8), .valido(v8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference for single-cycle ops, written from the op table.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.res = '0;
      e.ov  = 1'b0;
      case (op)
         4'h2: begin e.res = a + b; e.ov = (a[31] == b[31]) && (e.res[31] != a[31]); end
         4'h6: begin e.res = a - b; e.ov = (a[31] != b[31]) && (e.res[31] != a[31]); end
         4'h0: e.res = a & b;
         4'h1: e.res = a | b;
         4'h4: e.res = a ^ b;
         4'h5: e.res = ~(a | b);
         4'h7: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'hB: e.res = (a < b) ? 32'd1 : 32'd0;
         4'h8: e.res = a << b[4:0];
         4'h9: e.res = a >> b[4:0];
         4'hA: e.res = $unsigned($signed(a) >>> b[4:0]);
         default: e.res = '0;
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   // Advance one clock; sample at the falling edge and score any completion.
   task automatic step();
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      if (v32 === 1'b1) begin
         chk("valido32_expected", 32'(q32.size() != 0), 32'd1);
         if (q32.size() != 0) begin
            e = q32.pop_front();
            chk("res32", res32, e.res);
            chk("zero32", 32'(z32), 32'(e.z));
            chk("ovf32", 32'(ov32), 32'(e.ov));
         end
      end
      if (v8 === 1'b1) begin
         chk("valido8_expected", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("res8", {24'd0, res8}, e.res);
            chk("zero8", 32'(z8), 32'(e.z));
         end
      end
   endtask

   task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic eo);
      exp_t e;
      op32 = op; a32 = a; b32 = b; ini32 = 1'b1;
      e.res = er; e.z = (er == 32'd0); e.ov = eo;
      q32.push_back(e);
      step();
      ini32 = 1'b0;
   endtask

   // Called right after an iterative op was accepted; counts clocks to valido.
   task automatic wait_iter32(input string tag, input int lat_exp);
      int lat = 0;
      int oc  = (oc32 === 1'b1) ? 1 : 0;
      do begin
         step();
         lat++;
         if (oc32 === 1'b1) oc++;
      end while (v32 !== 1'b1 && lat < 200);
      chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
      chk({tag, "_ocupado_cycles"}, 32'(oc), 32'(lat_exp));
   endtask

   initial begin
      logic [3:0] sops [0:11] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h4, 4'h5,
                                  4'h7, 4'hB, 4'h8, 4'h9, 4'hA, 4'h3};
      exp_t e;
      int lat;
      int oc;
      rst = 1'b1; ini32 = 1'b0; ini8 = 1'b0;
      a32 = '0; b32 = '0; op32 = '0; a8 = '0; b8 = '0; op8 = '0;
      step(); step();
      chk("rst_resultado", res32, 32'd0);
      chk("rst_zero", 32'(z32), 32'd1);
      chk("rst_overflow", 32'(ov32), 32'd0);
      chk("rst_ocupado", 32'(oc32), 32'd0);
      chk("rst_valido", 32'(v32), 32'd0);
      chk("rst_resultado8", {24'd0, res8}, 32'd0);
      rst = 1'b0;
      step();

      // Single-cycle ops, back to back, one result per clock.
      issue32(4'h2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
      chk("add_valido_lat1", 32'(v32), 32'd1);
      issue32(4'h6, 32'd5, 32'd5, 32'd0, 1'b0);
      issue32(4'h7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
      issue32(4'hB, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      issue32(4'hA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
      issue32(4'h9, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
      issue32(4'h8, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
      issue32(4'h6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
      issue32(4'h3, 32'hDEAD_BEEF, 32'd7, 32'd0, 1'b0);
      step();
      chk("hold_after_idle", res32, 32'd0);
      chk("valido_one_pulse", 32'(v32), 32'd0);

      // Randomised single-cycle ops against the reference model.
      for (int i = 0; i < 16; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = sops[$urandom_range(0, 11)];
         a  = $urandom;
         b  = $urandom;
         e  = model(op, a, b);
         issue32(op, a, b, e.res, e.ov);
      end
      step();

      // Iterative ops: WIDTH+1 latency, ocupado for WIDTH+1 cycles.
      issue32(4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_iter32("mul", 33);
      issue32(4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      wait_iter32("mulhu", 33);
      issue32(4'hE, 32'd100, 32'd7, 32'd14, 1'b0);
      wait_iter32("divu", 33);
      issue32(4'hF, 32'd100, 32'd7, 32'd2, 1'b0);
      wait_iter32("remu", 33);
      issue32(4'hE, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0);
      wait_iter32("divu0", 33);
      issue32(4'hF, 32'd9, 32'd0, 32'd9, 1'b0);
      wait_iter32("remu0", 33);

      // Request held high during CALC is ignored, then accepted in the valido cycle.
      issue32(4'hC, 32'd6, 32'd7, 32'd42, 1'b0);
      repeat (5) step();
      op32 = 4'h2; a32 = 32'd3; b32 = 32'd4; ini32 = 1'b1;
      lat = 5;
      do begin
         step();
         lat++;
      end while (v32 !== 1'b1 && lat < 200);
      chk("mul_ignore_latency", 32'(lat), 32'd33);
      e.res = 32'd7; e.z = 1'b0; e.ov = 1'b0;
      q32.push_back(e);
      step();
      ini32 = 1'b0;
      chk("add_in_valido_cycle", 32'(v32), 32'd1);
      chk("queue_drained", 32'(q32.size()), 32'd0);

      // Reset in the middle of a divide: the op vanishes without a valido.
      op32 = 4'hE; a32 = 32'd1000; b32 = 32'd3; ini32 = 1'b1;
      step();
      ini32 = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_ocupado", 32'(oc32), 32'd0);
      chk("abort_resultado", res32, 32'd0);
      chk("abort_zero", 32'(z32), 32'd1);
      chk("abort_valido", 32'(v32), 32'd0);
      repeat (40) step();
      chk("abort_no_valido", 32'(q32.size()), 32'd0);

      // WIDTH=8 instance: MUL 15x17, latency 9.
      op8 = 4'hC; a8 = 8'd15; b8 = 8'd17; ini8 = 1'b1;
      e.res = 32'h0000_00FF; e.z = 1'b0; e.ov = 1'b0;
      q8.push_back(e);
      step();
      ini8 = 1'b0;
      lat = 0;
      oc = (oc8 === 1'b1) ? 1 : 0;
      do begin
         step();
         lat++;
         if (oc8 === 1'b1) oc++;
      end while (v8 !== 1'b1 && lat < 100);
      chk("mul8_latency", 32'(lat), 32'd9);
      chk("mul8_ocupado_cycles", 32'(oc), 32'd9);
      chk("queue8_drained", 32'(q8.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
